// File: rtl/cnn_layer_accel_result_packer.sv
// Packs C_RESULT_WIDTH quad results into C_OUT_WIDTH words, lane 0 first, with keep/last per job.
// Latency: packed word valid one cycle after the accept of its completing beat.
// Backpressure: stalled output holds; result_accept drops only on a completing beat while the output is full.
module cnn_layer_accel_result_packer #(
    parameter int C_RESULT_WIDTH = 16,
    parameter int C_OUT_WIDTH    = 128,
    parameter int C_COUNT_WIDTH  = 24
) (
    input  logic                                   clk_if,
    input  logic                                   rst,
    input  logic                                   cfg_start,
    input  logic [C_COUNT_WIDTH-1:0]               cfg_num_results,
    output logic                                   busy,
    output logic                                   done,
    input  logic                                   result_valid,
    output logic                                   result_accept,
    input  logic [C_RESULT_WIDTH-1:0]              result_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [C_OUT_WIDTH-1:0]                 out_data,
    output logic [C_OUT_WIDTH/C_RESULT_WIDTH-1:0]  out_keep,
    output logic                                   out_last
);

    localparam int LANES = C_OUT_WIDTH / C_RESULT_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PACK  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic                     rst_meta;
    logic                     rst_sync;
    logic [1:0]               state;
    logic [C_COUNT_WIDTH-1:0] remaining;
    logic [LW-1:0]            lane_cnt;
    logic [C_OUT_WIDTH-1:0]   acc;
    logic [C_OUT_WIDTH-1:0]   word_next;
    logic [LANES-1:0]         keep_next;
    logic                     completing;
    logic                     take;
    logic                     out_fire;
    logic                     last_result;

    // Reset asserts immediately but releases only on a clock edge, two flops deep.
    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    // Both terms come from registers, so result_accept never depends on result_valid.
    assign last_result   = (remaining == C_COUNT_WIDTH'(1));
    assign completing    = (lane_cnt == LW'(LANES - 1)) || last_result;
    assign result_accept = (state == S_PACK) && (!completing || !out_valid || out_ready);
    assign take          = result_valid && result_accept;
    assign out_fire      = out_valid && out_ready;
    assign busy          = (state != S_IDLE);

    // Merge the incoming result into its lane and build the keep mask for lanes 0..lane_cnt.
    always_comb begin
        word_next = acc;
        keep_next = '0;
        for (int l = 0; l < LANES; l++) begin
            if (LW'(l) == lane_cnt) begin
                word_next[l*C_RESULT_WIDTH +: C_RESULT_WIDTH] = result_data;
            end
            if (LW'(l) <= lane_cnt) begin
                keep_next[l] = 1'b1;
            end
        end
    end

    // Job control: counts results down, advances lanes, and signals done after the last word leaves.
    always_ff @(posedge clk_if or negedge rst_sync) begin
        if (!rst_sync) begin
            state     <= S_IDLE;
            remaining <= '0;
            lane_cnt  <= '0;
            acc       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_num_results != '0) begin
                            remaining <= cfg_num_results;
                            lane_cnt  <= '0;
                            acc       <= '0;
                            state     <= S_PACK;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_PACK: begin
                    if (take) begin
                        remaining <= remaining - C_COUNT_WIDTH'(1);
                        if (completing) begin
                            lane_cnt <= '0;
                            acc      <= '0;
                            if (last_result) begin
                                state <= S_DRAIN;
                            end
                        end else begin
                            lane_cnt <= lane_cnt + LW'(1);
                            acc      <= word_next;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_fire && out_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: a new load overrides a same-cycle handshake, otherwise a handshake empties it.
    always_ff @(posedge clk_if or negedge rst_sync) begin
        if (!rst_sync) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (take && completing) begin
            out_valid <= 1'b1;
            out_data  <= word_next;
            out_keep  <= keep_next;
            out_last  <= last_result;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
module tb_cnn_layer_accel_result_packer;

    logic         clk_if = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_start = 1'b0;
    logic [23:0]  cfg_num_results = '0;
    logic         busy;
    logic         done;
    logic         result_valid = 1'b0;
    logic         result_accept;
    logic [15:0]  result_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [7:0]   out_keep;
    logic         out_last;

    cnn_layer_accel_result_packer dut (
        .clk_if          (clk_if),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_num_results (cfg_num_results),
        .busy            (busy),
        .done            (done),
        .result_valid    (result_valid),
        .result_accept   (result_accept),
        .result_data     (result_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_keep        (out_keep),
        .out_last        (out_last)
    );

    always #5 clk_if = ~clk_if;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   keep;
        logic         last;
    } exp_word_t;

    typedef struct {
        int         count;
        int         stall;
        bit         mid;
        bit         rnd;
        int         exp_words;
        logic [7:0] exp_last_keep;
        logic [15:0] base;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exp_word_t   exp_q[$];
    logic [15:0] res[$];
    vec_t        tbl[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_done"}, 128'(done), 128'd0);
        chk({tag, "_accept"}, 128'(result_accept), 128'd0);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_out_data"}, out_data, 128'd0);
        chk({tag, "_out_keep"}, 128'(out_keep), 128'd0);
        chk({tag, "_out_last"}, 128'(out_last), 128'd0);
    endtask

    task automatic run_job(input vec_t v);
        int          sent = 0;
        int          words = 0;
        int          done_iter;
        int          stall_left = 0;
        bit          armed = 0;
        bit          last_stall;
        bit          finished = 0;
        bit          hold = 0;
        logic [127:0] h_data;
        logic [7:0]  h_keep;
        logic        h_last;
        logic [7:0]  last_keep = '0;
        exp_word_t   e;

        res.delete();
        exp_q.delete();
        for (int i = 0; i < v.count + 8; i++) begin
            res.push_back(v.rnd ? 16'($urandom) : 16'(v.base + 16'(i)));
        end
        for (int w = 0; w * 8 < v.count; w++) begin
            e.data = '0;
            e.keep = '0;
            for (int l = 0; l < 8; l++) begin
                if (w * 8 + l < v.count) begin
                    e.data[l*16 +: 16] = res[w*8+l];
                    e.keep[l] = 1'b1;
                end
            end
            e.last = (w * 8 + 8 >= v.count);
            exp_q.push_back(e);
        end

        done_iter = (v.count == 0) ? 0 : -1;
        @(negedge clk_if);
        cfg_start = 1'b1;
        cfg_num_results = 24'(v.count);
        @(negedge clk_if);

        for (int iter = 0; iter < 2000; iter++) begin
            if (iter > 0) @(negedge clk_if);
            cfg_start = v.mid && (iter == 2);
            cfg_num_results = (v.mid && iter == 2) ? 24'd99 : 24'(v.count);
            last_stall = 0;
            if (v.rnd) begin
                out_ready = 1'($urandom_range(0, 1));
            end else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                last_stall = (stall_left == 0);
            end else begin
                out_ready = 1'b1;
            end
            result_valid = 1'b1;
            result_data = res[sent];
            #1;

            chk("done", 128'(done), 128'(iter == done_iter));
            chk("busy", 128'(busy), 128'((v.count != 0) && (done_iter < 0 || iter < done_iter)));
            if (v.count == 0) chk("zero_out_valid", 128'(out_valid), 128'd0);
            if (hold) begin
                chk("hold_valid", 128'(out_valid), 128'd1);
                chk("hold_data", out_data, h_data);
                chk("hold_keep", 128'(out_keep), 128'(h_keep));
                chk("hold_last", 128'(out_last), 128'(h_last));
            end
            if (last_stall) begin
                chk("stall_accept", 128'(result_accept), 128'd0);
                chk("stall_sent", 128'(sent), 128'd15);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 128'(words), 128'(v.exp_words));
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", out_data, e.data);
                    chk("word_keep", 128'(out_keep), 128'(e.keep));
                    chk("word_last", 128'(out_last), 128'(e.last));
                end
                words++;
                last_keep = out_keep;
                if (out_last) done_iter = iter + 1;
            end
            if (result_valid && result_accept) begin
                sent++;
                if (v.stall > 0 && sent == 8 && !armed) begin
                    stall_left = v.stall;
                    armed = 1;
                end
            end
            hold = out_valid && !out_ready;
            h_data = out_data;
            h_keep = out_keep;
            h_last = out_last;
            if (iter == done_iter) begin
                finished = 1;
                break;
            end
        end

        result_valid = 1'b0;
        cfg_start = 1'b0;
        out_ready = 1'b1;
        chk("job_finished", 128'(finished), 128'd1);
        chk("results_consumed", 128'(sent), 128'(v.count));
        chk("word_count", 128'(words), 128'(v.exp_words));
        chk("words_pending", 128'(exp_q.size()), 128'd0);
        if (v.exp_words > 0) chk("last_keep", 128'(last_keep), 128'(v.exp_last_keep));
        if (!v.rnd && v.stall == 0 && v.count > 0) chk("throughput", 128'(done_iter), 128'(v.count + 1));
    endtask

    initial begin
        int sent;

        tbl[0] = '{count: 16,  stall: 0,  mid: 0, rnd: 0, exp_words: 2,  exp_last_keep: 8'hFF, base: 16'h0001};
        tbl[1] = '{count: 324, stall: 0,  mid: 0, rnd: 0, exp_words: 41, exp_last_keep: 8'h0F, base: 16'h1000};
        tbl[2] = '{count: 16,  stall: 10, mid: 0, rnd: 0, exp_words: 2,  exp_last_keep: 8'hFF, base: 16'h0A00};
        tbl[3] = '{count: 0,   stall: 0,  mid: 0, rnd: 0, exp_words: 0,  exp_last_keep: 8'h00, base: 16'h0000};
        tbl[4] = '{count: 8,   stall: 0,  mid: 1, rnd: 0, exp_words: 1,  exp_last_keep: 8'hFF, base: 16'h0B00};
        tbl[5] = '{count: 11,  stall: 0,  mid: 0, rnd: 1, exp_words: 2,  exp_last_keep: 8'h07, base: 16'h0000};
        tbl[6] = '{count: 1,   stall: 0,  mid: 0, rnd: 0, exp_words: 1,  exp_last_keep: 8'h01, base: 16'hBEEF};

        #2 rst = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk_if);
        rst = 1'b1;
        repeat (3) @(negedge clk_if);

        for (int t = 0; t < 7; t++) begin
            run_job(tbl[t]);
            repeat (2) @(negedge clk_if);
        end

        // Reset in the middle of a job after five results were taken.
        @(negedge clk_if);
        cfg_start = 1'b1;
        cfg_num_results = 24'd8;
        @(negedge clk_if);
        cfg_start = 1'b0;
        out_ready = 1'b1;
        result_valid = 1'b1;
        sent = 0;
        for (int i = 0; i < 20 && sent < 5; i++) begin
            if (i > 0) @(negedge clk_if);
            result_data = 16'h7700 + 16'(sent);
            #1;
            if (result_accept) sent++;
        end
        chk("midreset_sent", 128'(sent), 128'd5);
        @(negedge clk_if);
        rst = 1'b0;
        result_valid = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk_if);
        rst = 1'b1;
        repeat (3) @(negedge clk_if);
        run_job('{count: 8, stall: 0, mid: 0, rnd: 0, exp_words: 1, exp_last_keep: 8'hFF, base: 16'h0300});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_result_packer.md
CNN_LAYER_ACCEL_RESULT_PACKER -- requirements
Module: cnn_layer_accel_result_packer

Interface
REQ-001 SHALL have parameter C_RESULT_WIDTH, default 16, width of one quad result.
REQ-002 SHALL have parameter C_OUT_WIDTH, default 128, packed output word width; lanes = C_OUT_WIDTH/C_RESULT_WIDTH = 8.
REQ-003 SHALL have parameter C_COUNT_WIDTH, default 24, width of the result counter.
REQ-004 clk_if  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cfg_start  in  1  one-cycle job start pulse.
REQ-007 cfg_num_results  in  C_COUNT_WIDTH  total results in the job (rows x cols x kernels); sampled with cfg_start.
REQ-008 busy  out  1  high whenever state != IDLE.
REQ-009 done  out  1  one-cycle pulse at job completion.
REQ-010 result_valid  in  1  quad result valid.
REQ-011 result_accept  out  1  packer takes result this cycle.
REQ-012 result_data  in  C_RESULT_WIDTH  quad result.
REQ-013 out_valid  out  1  packed word valid.
REQ-014 out_ready  in  1  downstream ready.
REQ-015 out_data  out  C_OUT_WIDTH  packed word.
REQ-016 out_keep  out  8  one bit per filled lane.
REQ-017 out_last  out  1  marks the final word of the job.

Function
REQ-018 SHALL implement states IDLE, PACK, DRAIN.
REQ-019 IDLE: cfg_start with cfg_num_results != 0 -> load remaining = cfg_num_results, lane_cnt = 0, go PACK.
REQ-020 IDLE: cfg_start with cfg_num_results == 0 -> no output word, done pulses on the next cycle, stay IDLE.
REQ-021 cfg_start SHALL be ignored in PACK and DRAIN.
REQ-022 Result handshake: transfer when result_valid && result_accept; result_accept SHALL have no combinational path from result_valid.
REQ-023 completing beat = (lane_cnt == 7) || (remaining == 1), both registered.
REQ-024 result_accept = (state == PACK) && (!completing beat || !out_valid || out_ready).
REQ-025 Accepted result SHALL go to lane lane_cnt, bits [16*lane_cnt+15 : 16*lane_cnt]; lane 0 is first in time.
REQ-026 Each accepted result decrements remaining by 1; non-completing beats increment lane_cnt.
REQ-027 Completing beat: in the same edge, the full word loads into the output register: out_valid=1, out_keep = lanes 0..lane_cnt set, unfilled lanes zeroed, out_last = (remaining == 1); lane_cnt -> 0, accumulator cleared.
REQ-028 Latency: packed word valid on the cycle after its completing-beat accept.
REQ-029 out_valid, out_data, out_keep, out_last SHALL hold stable while out_valid && !out_ready.
REQ-030 Output handshake and a new load in the same cycle SHALL both occur: sustained 1 result/cycle with out_ready=1.
REQ-031 out_valid clears after handshake when no new load occurs.
REQ-032 On the last load, go DRAIN; results stay unaccepted, so none are consumed past cfg_num_results.
REQ-033 DRAIN: on out_valid && out_ready && out_last -> done=1 next cycle, state IDLE.
REQ-034 remaining SHALL never wrap below 0; lane_cnt wraps 7 -> 0 only via REQ-027.

Reset
REQ-035 rst low SHALL asynchronously force state=IDLE, busy=0, done=0, result_accept=0, out_valid=0, out_data=0, out_keep=0, out_last=0, lane_cnt=0, remaining=0.
REQ-036 Reset mid-job SHALL discard the partial word and pending output; the next job starts at lane 0.
REQ-037 Reset deassertion SHALL be used synchronously to clk_if internally.

Verification
REQ-038 count=16, results 0x0001..0x0010 back-to-back, out_ready=1 -> 2 words, keep 0xFF each, word0 lane0=0x0001 lane7=0x0008, word1 last=1, done 1 cycle after word1 handshake.
REQ-039 count=324 (20x20 input, 3x3 kernel, stride 1, 1 kernel) -> 41 words; words 0-39 keep 0xFF; word 40 keep 0x0F, lanes 4-7 zero, last=1.
REQ-040 count=16, out_ready low for 10 cycles after word0 -> result_accept low on the 16th beat until out_ready rises; word0 held stable; no result lost or duplicated.
REQ-041 cfg_start with count=0 -> done pulse next cycle, out_valid never asserts, busy stays 0.
REQ-042 rst low after 5 accepted results -> all outputs 0 immediately; new job count=8 yields 1 word with lane0 = first new result, keep 0xFF.
REQ-043 cfg_start with count=99 during PACK of a count=8 job -> ignored; exactly 1 word, last=1, then done.
